// File: rtl/vc_buffer.sv
// vc_buffer: router input VC buffer with FIFO storage, XY route computation and allocator handshake.
// Optional malformed-head discard enabled by defining VC_ERR_CHECK_EN.
module vc_buffer #(
   parameter int FLIT_W         = 8,
   parameter int FLIT_ID_W      = 2,
   parameter int COL_ADDR_W     = 2,
   parameter int ROW_ADDR_W     = 2,
   parameter int X_CORD         = 0,
   parameter int Y_CORD         = 0,
   parameter int BUFFER_DEPTH_W = 2,
   parameter int OUT_M          = 5
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [FLIT_W-1:0]        data_i,
   input  logic                     data_vld_i,
   output logic                     rdy_o,
   output logic [FLIT_W-1:0]        data_o,
   output logic [FLIT_ID_W-1:0]     flit_id_o,
   output logic                     data_vld_o,
   output logic [$clog2(OUT_M)-1:0] rtr_res_o,
   output logic                     rtr_res_vld_o,
   input  logic                     chan_alloc_i,
   output logic                     err_o
);
   localparam int DEPTH = 2**BUFFER_DEPTH_W;
   localparam int RES_W = $clog2(OUT_M);
   localparam logic [FLIT_ID_W-1:0] ID_HT = FLIT_ID_W'(0);
   localparam logic [FLIT_ID_W-1:0] ID_BD = FLIT_ID_W'(2);
   localparam logic [FLIT_ID_W-1:0] ID_TL = FLIT_ID_W'(3);
   localparam logic [COL_ADDR_W-1:0] X_C = COL_ADDR_W'(X_CORD);
   localparam logic [ROW_ADDR_W-1:0] Y_C = ROW_ADDR_W'(Y_CORD);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                    state, state_nxt;
   logic [FLIT_W-1:0]         mem [DEPTH];
   logic [BUFFER_DEPTH_W-1:0] wr_ptr, rd_ptr;
   logic [BUFFER_DEPTH_W:0]   count;
   logic                      empty, push, pop, grant, drop, route_en, last;
   logic [COL_ADDR_W-1:0]     dx;
   logic [ROW_ADDR_W-1:0]     dy;
   logic [RES_W-1:0]          route;

   assign empty     = count == '0;
   assign rdy_o     = count != (BUFFER_DEPTH_W+1)'(DEPTH);
   assign data_o    = mem[rd_ptr];
   assign flit_id_o = data_o[FLIT_W-1 -: FLIT_ID_W];
   assign dx        = data_o[COL_ADDR_W-1:0];
   assign dy        = data_o[COL_ADDR_W+ROW_ADDR_W-1:COL_ADDR_W];
   assign push      = data_vld_i && rdy_o;
   assign grant     = chan_alloc_i && data_vld_o;
   assign pop       = grant || drop;
   assign last      = flit_id_o == ID_HT || flit_id_o == ID_TL;
   // XY dimension-order routing: resolve the column first, then the row
   assign route     = dx > X_C ? RES_W'(3) :
                      dx < X_C ? RES_W'(1) :
                      dy > Y_C ? RES_W'(4) :
                      dy < Y_C ? RES_W'(2) : RES_W'(0);

   always_comb begin
      state_nxt  = state;
      route_en   = 1'b0;
      drop       = 1'b0;
      data_vld_o = 1'b0;
      if (state == IDLE && !empty) begin
`ifdef VC_ERR_CHECK_EN
         drop      = flit_id_o == ID_BD || flit_id_o == ID_TL;
         route_en  = !drop;
         state_nxt = drop ? IDLE : ACTIVE;
`else
         route_en  = 1'b1;
         state_nxt = ACTIVE;
`endif
      end
      if (state == ACTIVE) begin
         data_vld_o = rtr_res_vld_o && !empty;
         state_nxt  = grant && last ? IDLE : ACTIVE;
      end
   end

   always_ff @(posedge clk_i)
      if (push) mem[wr_ptr] <= data_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         rtr_res_o     <= '0;
         rtr_res_vld_o <= 1'b0;
      end else begin
         state  <= state_nxt;
         wr_ptr <= push ? wr_ptr + BUFFER_DEPTH_W'(1) : wr_ptr;
         rd_ptr <= pop ? rd_ptr + BUFFER_DEPTH_W'(1) : rd_ptr;
         count  <= count + (BUFFER_DEPTH_W+1)'(push) - (BUFFER_DEPTH_W+1)'(pop);
         if (route_en) begin
            rtr_res_o     <= route;
            rtr_res_vld_o <= 1'b1;
         end else if (grant && last) begin
            rtr_res_vld_o <= 1'b0;
         end
      end
   end

`ifdef VC_ERR_CHECK_EN
   always_ff @(posedge clk_i)
      err_o <= rst_ni && drop;
`else
   assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_vc_buffer.sv
// tb_vc_buffer: directed self-checking bench for vc_buffer placed at router (1,1).
module tb_vc_buffer;
   logic       clk_i = 1'b0;
   logic       rst_ni, data_vld_i, chan_alloc_i;
   logic [7:0] data_i;
   logic       rdy_o, data_vld_o, rtr_res_vld_o, err_o;
   logic [7:0] data_o;
   logic [1:0] flit_id_o;
   logic [2:0] rtr_res_o;
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] ht_flit [5] = '{8'h06, 8'h04, 8'h09, 8'h01, 8'h05};
   logic [2:0] ht_dir  [5] = '{3'd3, 3'd1, 3'd4, 3'd2, 3'd0};

   vc_buffer #(.X_CORD(1), .Y_CORD(1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .data_vld_i(data_vld_i),
      .rdy_o(rdy_o), .data_o(data_o), .flit_id_o(flit_id_o), .data_vld_o(data_vld_o),
      .rtr_res_o(rtr_res_o), .rtr_res_vld_o(rtr_res_vld_o), .chan_alloc_i(chan_alloc_i),
      .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [7:0] f);
      data_i     = f;
      data_vld_i = 1'b1;
      step();
      data_vld_i = 1'b0;
   endtask

   initial begin
      rst_ni = 1'b0; data_vld_i = 1'b0; chan_alloc_i = 1'b0; data_i = '0;
      step(); step();
      rst_ni = 1'b1;
      chk("rst_rdy", rdy_o, 1);
      chk("rst_dvld", data_vld_o, 0);
      chk("rst_rvld", rtr_res_vld_o, 0);
      chk("rst_res", rtr_res_o, 0);
      chk("rst_err", err_o, 0);
      // HEAD east, then BODY and TAIL, then grant three consecutive cycles
      push(8'h46);
      chk("h_lat_dvld", data_vld_o, 0);
      chk("h_lat_data", data_o, 8'h46);
      step();
      chk("h_rvld", rtr_res_vld_o, 1);
      chk("h_res", rtr_res_o, 3);
      chk("h_dvld", data_vld_o, 1);
      chk("h_id", flit_id_o, 1);
      push(8'h80);
      push(8'hC0);
      chan_alloc_i = 1'b1;
      step();
      chk("p1_id", flit_id_o, 2);
      chk("p1_dvld", data_vld_o, 1);
      step();
      chk("p2_id", flit_id_o, 3);
      chk("p2_dvld", data_vld_o, 1);
      step();
      chan_alloc_i = 1'b0;
      chk("p3_dvld", data_vld_o, 0);
      chk("p3_rvld", rtr_res_vld_o, 0);
      chk("p3_res_hold", rtr_res_o, 3);
      chk("p3_rdy", rdy_o, 1);
      chk("p3_err", err_o, 0);
      // every XY direction with single-flit packets
      for (int i = 0; i < 5; i++) begin
         push(ht_flit[i]);
         chk("ht_lat", data_vld_o, 0);
         step();
         chk("ht_dvld", data_vld_o, 1);
         chk("ht_res", rtr_res_o, ht_dir[i]);
         chan_alloc_i = 1'b1;
         step();
         chan_alloc_i = 1'b0;
         chk("ht_done_dvld", data_vld_o, 0);
         chk("ht_done_rvld", rtr_res_vld_o, 0);
      end
      // fill to depth 4, fifth flit refused until a grant frees a slot
      push(8'h46);
      push(8'h80);
      push(8'h80);
      push(8'hC0);
      chk("full_rdy", rdy_o, 0);
      push(8'h05);
      chk("full_rdy2", rdy_o, 0);
      chk("full_head", data_o, 8'h46);
      data_i = 8'h05; data_vld_i = 1'b1; chan_alloc_i = 1'b1;
      step();
      chan_alloc_i = 1'b0;
      chk("free_rdy", rdy_o, 1);
      chk("free_id", flit_id_o, 2);
      step();
      data_vld_i = 1'b0;
      chk("refill_rdy", rdy_o, 0);
      chan_alloc_i = 1'b1;
      step();
      chk("d1_id", flit_id_o, 2);
      step();
      chk("d2_id", flit_id_o, 3);
      step();
      chk("d3_dvld", data_vld_o, 0);
      chk("d3_rvld", rtr_res_vld_o, 0);
      chk("d3_data", data_o, 8'h05);
      step();
      chk("d4_dvld", data_vld_o, 1);
      chk("d4_res", rtr_res_o, 0);
      step();
      chan_alloc_i = 1'b0;
      chk("d5_dvld", data_vld_o, 0);
      chk("d5_rdy", rdy_o, 1);
      // BODY first: routed as a head in the default build (dx=0 -> WEST)
      push(8'h80);
      chk("bd_err0", err_o, 0);
      step();
      chk("bd_dvld", data_vld_o, 1);
      chk("bd_res", rtr_res_o, 1);
      chk("bd_err", err_o, 0);
      // reset mid-packet with three flits buffered
      push(8'hC0);
      push(8'h41);
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      chk("mr_rdy", rdy_o, 1);
      chk("mr_dvld", data_vld_o, 0);
      chk("mr_rvld", rtr_res_vld_o, 0);
      chk("mr_res", rtr_res_o, 0);
      push(8'h06);
      push(8'h80);
      push(8'h80);
      chk("mr_rdy3", rdy_o, 1);
      push(8'hC0);
      chk("mr_rdy4", rdy_o, 0);
      chk("mr_head", data_o, 8'h06);
      chk("mr_res2", rtr_res_o, 3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
